// File: rtl/mlp_layer_sequencer_pkg.sv
// Shared MLP definitions: address field widths and bit positions, sequencer
// state encoding and the largest layer dimensions the address map can express.
package mlp_layer_sequencer_pkg;

    localparam int LAYER_W  = 2;
    localparam int NEURON_W = 4;
    localparam int INPUT_W  = 10;
    localparam int ADDR_W   = LAYER_W + NEURON_W + INPUT_W;

    // weight_addr = {layer, neuron, input}
    localparam int INPUT_LSB  = 0;
    localparam int NEURON_LSB = INPUT_W;
    localparam int LAYER_LSB  = INPUT_W + NEURON_W;

    localparam int MAX_NEURONS = 16;
    localparam int MAX_INPUTS  = 1024;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_WB,
        S_DONE
    } seq_state_t;

endpackage

// File: rtl/mlp_layer_sequencer.sv
// mlp_layer_sequencer: walks one MLP layer, issuing one weight address per
// cycle per neuron and generating the MAC control strobes that line up with
// a weight memory having one cycle of read latency.
//
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   start                    run request, only looked at while idle
//   layer_idx                layer to run
//   num_neurons, num_inputs  layer dimensions (clamped to the address map)
//   busy                     high whenever not idle
//   done                     one-cycle pulse at end of a run
//   weight_addr, input_idx   {layer,neuron,input} and its input field
//   mac_clear                first issue cycle of each neuron
//   mac_en, mac_last         accumulate strobe (issue delayed 1) / final term
//   out_valid, out_neuron    per-neuron result strobe and neuron index
module mlp_layer_sequencer #(
    parameter int ADDR_W   = mlp_layer_sequencer_pkg::ADDR_W,
    parameter int LAYER_W  = mlp_layer_sequencer_pkg::LAYER_W,
    parameter int NEURON_W = mlp_layer_sequencer_pkg::NEURON_W,
    parameter int INPUT_W  = mlp_layer_sequencer_pkg::INPUT_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [LAYER_W-1:0]  layer_idx,
    input  logic [NEURON_W:0]   num_neurons,
    input  logic [INPUT_W:0]    num_inputs,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W-1:0]   weight_addr,
    output logic [INPUT_W-1:0]  input_idx,
    output logic                mac_clear,
    output logic                mac_en,
    output logic                mac_last,
    output logic                out_valid,
    output logic [NEURON_W-1:0] out_neuron
);
    import mlp_layer_sequencer_pkg::*;

    localparam int NCNT_W = NEURON_W + 1;
    localparam int ICNT_W = INPUT_W + 1;
    localparam logic [NCNT_W-1:0] N_MAX = NCNT_W'(1 << NEURON_W);
    localparam logic [ICNT_W-1:0] I_MAX = ICNT_W'(1 << INPUT_W);

    seq_state_t           state;
    logic [LAYER_W-1:0]   layer_q;
    logic [NCNT_W-1:0]    nn_q;
    logic [ICNT_W-1:0]    ni_q;
    logic [NEURON_W-1:0]  neuron;
    logic [INPUT_W-1:0]   idx;

    logic [NCNT_W-1:0]    nn_clamp;
    logic [ICNT_W-1:0]    ni_clamp;
    logic                 last_term;
    logic                 last_neuron;

    // Counts beyond what the address fields can encode saturate at the field size.
    assign nn_clamp = (num_neurons > N_MAX) ? N_MAX : num_neurons;
    assign ni_clamp = (num_inputs  > I_MAX) ? I_MAX : num_inputs;

    // Counts are non-zero whenever these are consulted (zero runs skip ISSUE/WB).
    assign last_term   = ({1'b0, idx}    == (ni_q - ICNT_W'(1)));
    assign last_neuron = ({1'b0, neuron} == (nn_q - NCNT_W'(1)));

    assign input_idx = weight_addr[INPUT_W-1:0];

    function automatic logic [ADDR_W-1:0] addr_of(input logic [LAYER_W-1:0]  l,
                                                  input logic [NEURON_W-1:0] n,
                                                  input logic [INPUT_W-1:0]  i);
        return ADDR_W'({l, n, i});
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            layer_q     <= '0;
            nn_q        <= '0;
            ni_q        <= '0;
            neuron      <= '0;
            idx         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            weight_addr <= '0;
            mac_clear   <= 1'b0;
            mac_en      <= 1'b0;
            mac_last    <= 1'b0;
            out_valid   <= 1'b0;
            out_neuron  <= '0;
        end else begin
            // The weight read returns one cycle after its address is issued,
            // so the accumulate strobes are simply the issue cycle delayed.
            mac_en   <= (state == S_ISSUE);
            mac_last <= (state == S_ISSUE) && last_term;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        layer_q <= layer_idx;
                        nn_q    <= nn_clamp;
                        ni_q    <= ni_clamp;
                        neuron  <= '0;
                        idx     <= '0;
                        busy    <= 1'b1;
                        if (nn_clamp == '0 || ni_clamp == '0) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            weight_addr <= addr_of(layer_idx, '0, '0);
                            mac_clear   <= 1'b1;
                            state       <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    mac_clear <= 1'b0;
                    if (last_term) begin
                        state <= S_WAIT;
                    end else begin
                        idx         <= idx + 1'b1;
                        weight_addr <= addr_of(layer_q, neuron, idx + 1'b1);
                    end
                end
                S_WAIT: begin
                    out_valid  <= 1'b1;
                    out_neuron <= neuron;
                    state      <= S_WB;
                end
                S_WB: begin
                    out_valid <= 1'b0;
                    if (last_neuron) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        neuron      <= neuron + 1'b1;
                        idx         <= '0;
                        weight_addr <= addr_of(layer_q, neuron + 1'b1, '0);
                        mac_clear   <= 1'b1;
                        state       <= S_ISSUE;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mlp_layer_sequencer.sv
// Directed bench for mlp_layer_sequencer: a table of layer runs, each checked
// cycle by cycle against an expected trace built from the layer dimensions,
// plus hand-written sequences for mid-run reset and the weight-memory path.
module tb_mlp_layer_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  layer_idx;
    logic [4:0]  num_neurons;
    logic [10:0] num_inputs;
    logic        busy, done, mac_clear, mac_en, mac_last, out_valid;
    logic [15:0] weight_addr;
    logic [9:0]  input_idx;
    logic [3:0]  out_neuron;

    mlp_layer_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .layer_idx(layer_idx),
        .num_neurons(num_neurons), .num_inputs(num_inputs), .busy(busy),
        .done(done), .weight_addr(weight_addr), .input_idx(input_idx),
        .mac_clear(mac_clear), .mac_en(mac_en), .mac_last(mac_last),
        .out_valid(out_valid), .out_neuron(out_neuron)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    bit poke   = 1'b0;

    // Expected held values of weight_addr / out_neuron outside their strobes.
    logic [15:0] hold_addr = '0;
    logic [3:0]  hold_neu  = '0;

    // Small weight memory with one cycle of read latency.
    logic signed [7:0] rdata;
    logic [8:0]        macq[$];

    function automatic logic signed [7:0] wmem(input logic [15:0] a);
        case (a)
            16'h4000: return -8'sd4;
            16'h4001: return -8'sd5;
            16'h4400: return 8'sd6;
            16'h4401: return 8'sd2;
            default:  return 8'(a[7:0] ^ a[15:8]);
        endcase
    endfunction

    always @(posedge clk) rdata <= wmem(weight_addr);
    always @(negedge clk) if (mac_en) macq.push_back({mac_last, rdata});

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s (cycle %0d): got %h expected %h", name, cyc, act, exp);
    endtask

    function automatic logic [26:0] outvec();
        return {busy, done, mac_clear, mac_en, mac_last, out_valid, out_neuron, weight_addr,
                (input_idx == weight_addr[9:0])};
    endfunction

    // Advance one cycle and compare every output against the expected values.
    task automatic step(input string name, input bit b, input bit d, input bit clr,
                        input bit en, input bit last, input bit ov);
        @(negedge clk);
        cyc++;
        if (poke) start = (cyc == 2 || cyc == 3);
        check(name, 64'(outvec()), 64'({b, d, clr, en, last, ov, hold_neu, hold_addr, 1'b1}));
    endtask

    task automatic run_layer(input logic [1:0] l, input logic [4:0] nn, input logic [10:0] ni,
                             input int exp_lat, input bit do_poke, input bit now);
        int m, n;
        m = (nn > 5'd16) ? 16 : int'(nn);
        n = (ni > 11'd1024) ? 1024 : int'(ni);
        if (!now) @(negedge clk);
        start = 1'b1; layer_idx = l; num_neurons = nn; num_inputs = ni;
        @(posedge clk);
        #1;
        // Scramble the config inputs: the latched copy must be used.
        start = 1'b0; layer_idx = ~l; num_neurons = 5'd3; num_inputs = 11'd7;
        cyc  = 0;
        poke = do_poke;
        if (m > 0 && n > 0) begin
            for (int j = 0; j < m; j++) begin
                for (int i = 0; i < n; i++) begin
                    hold_addr = {l, 4'(j), 10'(i)};
                    step("issue", 1'b1, 1'b0, (i == 0), (i > 0), 1'b0, 1'b0);
                end
                step("wait", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
                hold_neu = 4'(j);
                step("wb", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            end
        end
        step("done", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("done_latency", 64'(cyc), 64'(exp_lat));
        step("idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        if (do_poke)
            repeat (8) step("no_second_run", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        poke  = 1'b0;
        start = 1'b0;
    endtask

    typedef struct {
        logic [1:0]  l;
        logic [4:0]  nn;
        logic [10:0] ni;
        int          lat;
        bit          poke;
    } vec_t;

    vec_t vecs[7];

    initial begin
        vecs[0] = '{2'd0, 5'd2,  11'd4,    13,    1'b0};  // 2x4 layer 0
        vecs[1] = '{2'd1, 5'd2,  11'd2,    9,     1'b0};  // 2x2 layer 1, weights checked
        vecs[2] = '{2'd3, 5'd3,  11'd3,    16,    1'b0};
        vecs[3] = '{2'd2, 5'd1,  11'd4,    7,     1'b1};  // start pulsed while busy
        vecs[4] = '{2'd0, 5'd0,  11'd5,    1,     1'b0};  // zero neurons
        vecs[5] = '{2'd1, 5'd3,  11'd0,    1,     1'b0};  // zero inputs
        vecs[6] = '{2'd2, 5'd31, 11'd2047, 16417, 1'b0};  // clamped to 16x1024

        reset = 1'b1; start = 1'b0; layer_idx = '0; num_neurons = '0; num_inputs = '0;
        repeat (3) @(negedge clk);
        check("reset_state", 64'(outvec()), 64'(27'd1));
        reset = 1'b0;

        for (int k = 0; k < 7; k++) begin
            macq.delete();
            run_layer(vecs[k].l, vecs[k].nn, vecs[k].ni, vecs[k].lat, vecs[k].poke, 1'b0);
            if (k == 1) begin
                check("mac_count", 64'(macq.size()), 64'd4);
                if (macq.size() == 4) begin
                    check("mac_w0", 64'(macq[0]), 64'({1'b0, -8'sd4}));
                    check("mac_w1", 64'(macq[1]), 64'({1'b1, -8'sd5}));
                    check("mac_w2", 64'(macq[2]), 64'({1'b0, 8'sd6}));
                    check("mac_w3", 64'(macq[3]), 64'({1'b1, 8'sd2}));
                end
            end
            if (k == 4 || k == 5) check("zero_run_no_mac", 64'(macq.size()), 64'd0);
            if (k == 6) begin
                check("clamp_last_neuron", 64'(out_neuron), 64'd15);
                check("clamp_last_addr", 64'(weight_addr), 64'({2'd2, 4'd15, 10'd1023}));
            end
        end

        // Reset during ISSUE of neuron 1 of a 2x3 run on layer 1.
        @(negedge clk);
        start = 1'b1; layer_idx = 2'd1; num_neurons = 5'd2; num_inputs = 11'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc   = 0;
        repeat (6) begin
            @(negedge clk);
            cyc++;
        end
        check("pre_reset_addr", 64'(weight_addr), 64'h4400);
        reset = 1'b1;
        @(negedge clk);
        check("reset_midrun", 64'(outvec()), 64'(27'd1));
        hold_addr = '0;
        hold_neu  = '0;
        // Start on the very first cycle after reset releases; 1x1 run.
        reset = 1'b0;
        run_layer(2'd3, 5'd1, 11'd1, 4, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mlp_layer_sequencer.md
MLP_LAYER_SEQUENCER -- requirements
Module: mlp_layer_sequencer

Interface
REQ-001 Parameters:
- ADDR_W, default 16, weight address width.
- LAYER_W, default 2, layer field width (addr[15:14]).
- NEURON_W, default 4, neuron field width (addr[13:10]).
- INPUT_W, default 10, input-index field width (addr[9:0]).

REQ-002 Ports (clock and reset first):
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  request a layer run; sampled only in IDLE.
- layer_idx  in  LAYER_W  layer to run.
- num_neurons  in  NEURON_W+1  neurons in layer, 0..16.
- num_inputs  in  INPUT_W+1  inputs per neuron, 0..1024.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse at end of run.
- weight_addr  out  ADDR_W  {layer, neuron, input} to the weight memory.
- input_idx  out  INPUT_W  activation index, equal to weight_addr[9:0].
- mac_clear  out  1  clear accumulator; first issue cycle of each neuron.
- mac_en  out  1  accumulate; aligned with the weight memory's registered output.
- mac_last  out  1  high with mac_en on the final term of a neuron.
- out_valid  out  1  neuron result ready, one-cycle pulse.
- out_neuron  out  NEURON_W  neuron index qualified by out_valid.

Function
REQ-003 States: IDLE, ISSUE, WAIT, WB, DONE.

REQ-004 IDLE with start=1:
- Latch layer_idx, num_neurons and num_inputs.
- If either count is 0, go to DONE.
- Otherwise go to ISSUE with neuron=0, i=0.

REQ-005 Latched configuration is used for the whole run; changes on the config inputs mid-run have no effect.

REQ-006 Clamping: num_neurons>16 is treated as 16; num_inputs>1024 is treated as 1024.

REQ-007 ISSUE:
- One address per cycle: weight_addr={layer,neuron,i}, i=0..N-1, N=num_inputs.
- mac_clear=1 on the i=0 cycle only.
- After the i=N-1 cycle, go to WAIT.

REQ-008 mac_en is the issue-valid signal delayed by exactly 1 cycle, matching the 1-cycle weight read latency. mac_last is asserted with the mac_en of term N-1.

REQ-009 WAIT: one cycle carrying the final mac_en/mac_last. No new address is issued.

REQ-010 WB:
- out_valid=1 and out_neuron=neuron for one cycle.
- If neuron<num_neurons-1: increment neuron, set i=0, go to ISSUE.
- Otherwise go to DONE.

REQ-011 DONE: done=1 for one cycle, then IDLE.

REQ-012 Timing: per-neuron cost is N+2 cycles. A run of M neurons asserts done M*(N+2)+1 cycles after the start-accept edge.

REQ-013 start while busy=1 is ignored and is not queued.

REQ-014 weight_addr is held at its last value outside ISSUE. mac_clear, mac_en, mac_last, out_valid and done are 0 outside the cycles defined above.

REQ-015 N=1: mac_clear and issue occur in the same single ISSUE cycle. mac_en and mac_last both assert in WAIT.

Reset
REQ-016 reset=1 at any cycle, including mid-run:
- State goes to IDLE.
- Outputs clear: busy, done, mac_clear, mac_en, mac_last, out_valid = 0; weight_addr, input_idx, out_neuron = 0.
- Counters and latched configuration clear to 0.
- The interrupted run is abandoned with no done pulse.

REQ-017 The first start is accepted on the first cycle after reset deasserts.

Structure
REQ-018 The shared MLP package holds:
- Field widths LAYER_W, NEURON_W, INPUT_W and the address-field bit positions.
- The state enum.
- MAX_NEURONS=16 and MAX_INPUTS=1024.

REQ-019 The block is a single module with no sub-modules. The weight memory is instantiated by the parent, not by this block.

Verification
REQ-020 Layer 0, 2 neurons x 4 inputs:
- Addresses 0000,0001,0002,0003 then 0400..0403.
- mac_clear on 0000 and 0400.
- out_valid with out_neuron 0 then 1.
- done 13 cycles after accept.

REQ-021 Layer 1, 2x2 with weight memory attached:
- Addresses 4000,4001,4400,4401.
- mac_en samples weight values -4,-5 then 6,2.
- mac_last on -5 and 2.

REQ-022 num_inputs=0 or num_neurons=0: done 1 cycle after accept; mac_en, mac_clear and out_valid never asserted.

REQ-023 start pulsed while busy during a 1x4 run: still exactly one done, with no second run.

REQ-024 reset asserted in ISSUE of neuron 1: all outputs 0 next cycle, no done; a new start 1x1 then completes with done 4 cycles after accept.

REQ-025 num_neurons=31 and num_inputs=2047 are clamped: the last out_neuron is 15 and the last address is {layer,15,1023}.
